// File: rtl/jstk_spi_reader_pkg.sv
// Shared types and constants for the joystick SPI reader.
package jstk_spi_reader_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StGap,
        StDone
    } state_t;

    localparam int unsigned NumBytes  = 5;
    localparam logic [5:0]  CmdPrefix = 6'b100000;
    localparam logic [9:0]  JoyCentre = 10'd512;

    // First byte sent each transaction: fixed prefix plus LED command bits
    function automatic logic [7:0] cmd_byte(input logic [1:0] leds);
        return {CmdPrefix, leds};
    endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// 8-bit SPI mode-0 shift engine: MSB first, sample on rising, shift on falling.
module jstk_spi_byte #(
    parameter int unsigned SCLK_HALF = 50
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       i_start,
    input  logic [7:0] i_tx,
    input  logic       i_miso,
    output logic [7:0] o_rx,
    output logic       o_done,
    output logic       o_sclk,
    output logic       o_mosi
);

    logic        r_busy;
    logic        r_sclk;
    logic        r_done;
    logic [31:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        w_half;

    assign w_half = r_busy && (r_cnt == SCLK_HALF - 1);

    // Half-period timer, sclk toggle, and the tx/rx shift registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_busy <= 1'b0;
            r_sclk <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_busy <= 1'b1;
                r_sclk <= 1'b0;
                r_cnt  <= '0;
                r_bit  <= '0;
                r_tx   <= i_tx;
            end else if (r_busy) begin
                if (w_half) begin
                    r_cnt  <= '0;
                    r_sclk <= ~r_sclk;
                    if (!r_sclk) begin
                        r_rx <= {r_rx[6:0], i_miso};
                    end else begin
                        // Falling edge: next MSB appears while sclk is low
                        r_tx  <= {r_tx[6:0], 1'b0};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign o_rx   = r_rx;
    assign o_done = r_done;
    assign o_sclk = r_sclk;
    assign o_mosi = r_busy & r_tx[7];

endmodule

// File: rtl/jstk_spi_reader.sv
// Periodic 5-byte SPI poll of a joystick; publishes X/Y/buttons atomically.
module jstk_spi_reader
    import jstk_spi_reader_pkg::*;
#(
    parameter int unsigned SCLK_HALF   = 50,
    parameter int unsigned SS_SETUP    = 1500,
    parameter int unsigned BYTE_GAP    = 1000,
    parameter int unsigned POLL_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] leds,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] buttons,
    output logic       sample_valid
);

    state_t      r_state;
    state_t      w_state_d;
    logic [31:0] r_poll;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [1:0]  r_leds;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_joy_x;
    logic [9:0]  r_joy_y;
    logic [2:0]  r_buttons;
    logic        w_tick;
    logic        w_cnt_done;
    logic        w_last;
    logic        w_start;
    logic        w_done;
    logic [7:0]  w_rx;
    logic [7:0]  w_tx;

    assign w_tick     = (r_poll == POLL_PERIOD - 1);
    assign w_cnt_done = ((r_state == StSetup) && (r_cnt == SS_SETUP - 1)) ||
                        ((r_state == StGap)   && (r_cnt == BYTE_GAP - 1));
    assign w_last     = (r_idx == 3'(NumBytes - 1));
    assign w_tx       = (r_idx == 3'd0) ? cmd_byte(r_leds) : 8'h00;

    jstk_spi_byte #(
        .SCLK_HALF (SCLK_HALF)
    ) u_byte (
        .clk     (clk),
        .clr     (clr),
        .i_start (w_start),
        .i_tx    (w_tx),
        .i_miso  (miso),
        .o_rx    (w_rx),
        .o_done  (w_done),
        .o_sclk  (sclk),
        .o_mosi  (mosi)
    );

    // Next-state logic; a poll tick outside StIdle is simply ignored
    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle:  if (w_tick) w_state_d = StSetup;
            StSetup: if (w_cnt_done) begin
                w_state_d = StShift;
                w_start   = 1'b1;
            end
            StShift: if (w_done) w_state_d = w_last ? StDone : StGap;
            StGap:   if (w_cnt_done) begin
                w_state_d = StShift;
                w_start   = 1'b1;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register, free-running poll counter and per-state dwell counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= StIdle;
            r_poll  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_poll  <= w_tick ? 32'd0 : r_poll + 32'd1;
            r_cnt   <= (w_state_d != r_state) ? 32'd0 : r_cnt + 32'd1;
        end
    end

    // Collect received bytes into staging; outputs change only on the final byte
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_idx     <= '0;
            r_leds    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_joy_x   <= JoyCentre;
            r_joy_y   <= JoyCentre;
            r_buttons <= '0;
        end else begin
            if (r_state == StIdle && w_tick) begin
                r_idx  <= '0;
                r_leds <= leds;
                r_x    <= '0;
                r_y    <= '0;
            end else if (r_state == StShift && w_done) begin
                r_idx <= r_idx + 3'd1;
                case (r_idx)
                    3'd0:    r_x[7:0] <= w_rx;
                    3'd1:    r_x[9:8] <= w_rx[1:0];
                    3'd2:    r_y[7:0] <= w_rx;
                    3'd3:    r_y[9:8] <= w_rx[1:0];
                    default: begin
                        r_joy_x   <= r_x;
                        r_joy_y   <= r_y;
                        r_buttons <= w_rx[2:0];
                    end
                endcase
            end
        end
    end

    assign ss           = !(r_state inside {StSetup, StShift, StGap});
    assign sample_valid = (r_state == StDone);
    assign joy_x        = r_joy_x;
    assign joy_y        = r_joy_y;
    assign buttons      = r_buttons;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Self-checking bench for jstk_spi_reader with a behavioural joystick model.
module tb_jstk_spi_reader;

    localparam int SclkHalf   = 2;
    localparam int SsSetup    = 6;
    localparam int ByteGap    = 4;
    localparam int PollPeriod = 400;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] leds = 2'b00;
    logic       miso = 1'b0;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic [9:0] joy_x;
    logic [9:0] joy_y;
    logic [2:0] buttons;
    logic       sample_valid;

    jstk_spi_reader #(
        .SCLK_HALF   (SclkHalf),
        .SS_SETUP    (SsSetup),
        .BYTE_GAP    (ByteGap),
        .POLL_PERIOD (PollPeriod)
    ) u_dut (
        .clk          (clk),
        .clr          (clr),
        .leds         (leds),
        .miso         (miso),
        .ss           (ss),
        .sclk         (sclk),
        .mosi         (mosi),
        .joy_x        (joy_x),
        .joy_y        (joy_y),
        .buttons      (buttons),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] stream;  // b0 in [39:32] .. b4 in [7:0]
        logic [1:0]  leds;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [7:0]  cmd;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Joystick / bus monitor state
    logic [39:0] stream = '0;
    logic [39:0] mosi_bits = '0;
    int   cyc = 0, t_ss = 0, t_rise = 0, t_fall = 0;
    int   rise_cnt = 0, bit_idx = 0, tim_err = 0, sv_cnt = 0;
    logic prev_ss = 1'b1, prev_sclk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode from the byte stream using plain arithmetic
    function automatic vec_t model(input logic [39:0] s, input logic [1:0] l);
        vec_t v;
        int   b[5];
        for (int i = 0; i < 5; i++) b[i] = int'((s >> (8 * (4 - i))) & 40'hFF);
        v.stream = s;
        v.leds   = l;
        v.x      = 10'((b[1] % 4) * 256 + b[0]);
        v.y      = 10'((b[3] % 4) * 256 + b[2]);
        v.btn    = 3'(b[4] % 8);
        v.cmd    = 8'(128 + int'(l));
        return v;
    endfunction

    // Slave model: present a bit at SS fall and after each SCLK fall; record MOSI and timing
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_ss && ss === 1'b0) begin
            t_ss      = cyc;
            rise_cnt  = 0;
            tim_err   = 0;
            sv_cnt    = 0;
            bit_idx   = 0;
            mosi_bits = '0;
            miso      = stream[39];
        end
        if (!prev_sclk && sclk === 1'b1) begin
            if (rise_cnt == 0) begin
                if (cyc - t_ss < SsSetup) tim_err++;
            end else if (rise_cnt % 8 == 0) begin
                if (cyc - t_fall < ByteGap) tim_err++;
            end else if (cyc - t_rise != 2 * SclkHalf) begin
                tim_err++;
            end
            if (rise_cnt < 40) mosi_bits[39 - rise_cnt] = mosi;
            t_rise = cyc;
            rise_cnt++;
        end
        if (prev_sclk && sclk === 1'b0) begin
            t_fall = cyc;
            bit_idx++;
            miso = (bit_idx < 40) ? stream[39 - bit_idx] : 1'b0;
        end
        if (sample_valid === 1'b1) sv_cnt++;
        prev_ss   = (ss !== 1'b0);
        prev_sclk = (sclk === 1'b1);
    end

    // From reset release, count cycles until SS falls and any stray sample_valid
    task automatic measure_start(input string tag);
        int n = 0;
        int svs = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 3 * PollPeriod; i++) begin
            @(negedge clk);
            n++;
            if (sample_valid === 1'b1) svs++;
            if (ss === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_ss_fall_seen"}, 64'(seen), 64'd1);
        chk({tag, "_start_delay"}, 64'(n), 64'(PollPeriod));
        chk({tag, "_no_sv_before_start"}, 64'(svs), 64'd0);
    endtask

    // Wait for the sample of the current transaction and compare everything against v
    task automatic run_check(input vec_t v, input string tag);
        bit   got = 1'b0;
        logic ss_prev = 1'b1;
        stream = v.stream;
        leds   = v.leds;
        for (int i = 0; i < 3 * PollPeriod; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            ss_prev = ss;
        end
        chk({tag, "_sv_seen"}, 64'(got), 64'd1);
        if (!got) return;
        chk({tag, "_ss_low_before_sv"}, 64'(ss_prev), 64'd0);
        chk({tag, "_ss_high_at_sv"}, 64'(ss), 64'd1);
        chk({tag, "_joy_x"}, 64'(joy_x), 64'(v.x));
        chk({tag, "_joy_y"}, 64'(joy_y), 64'(v.y));
        chk({tag, "_buttons"}, 64'(buttons), 64'(v.btn));
        repeat (3) @(negedge clk);
        chk({tag, "_rise_count"}, 64'(rise_cnt), 64'd40);
        chk({tag, "_mosi_stream"}, 64'(mosi_bits), 64'({v.cmd, 32'h0}));
        chk({tag, "_timing_errs"}, 64'(tim_err), 64'd0);
        chk({tag, "_sv_pulses"}, 64'(sv_cnt), 64'd1);
        chk({tag, "_joy_x_hold"}, 64'(joy_x), 64'(v.x));
    endtask

    vec_t tbl[4];
    vec_t v;

    initial begin
        tbl[0] = '{40'h2C_03_10_01_05, 2'b10, 10'd812,  10'd272,  3'b101, 8'h82};
        tbl[1] = '{40'hFF_FF_FF_FF_FF, 2'b01, 10'd1023, 10'd1023, 3'b111, 8'h81};
        tbl[2] = '{40'h00_00_00_00_00, 2'b00, 10'd0,    10'd0,    3'b000, 8'h80};
        tbl[3] = '{40'h00_FC_FF_FE_F8, 2'b11, 10'd0,    10'd767,  3'b000, 8'h83};

        // Reset values while clr is held
        stream = tbl[0].stream;
        leds   = tbl[0].leds;
        #2 clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss", 64'(ss), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_joy_x", 64'(joy_x), 64'd512);
        chk("rst_joy_y", 64'(joy_y), 64'd512);
        chk("rst_buttons", 64'(buttons), 64'd0);
        chk("rst_sv", 64'(sample_valid), 64'd0);
        clr = 1'b0;
        measure_start("rst");

        // Table vectors
        for (int k = 0; k < 4; k++) run_check(tbl[k], $sformatf("tbl%0d", k));

        // Randomized transactions
        for (int k = 0; k < 6; k++) begin
            v = model({8'($urandom), 32'($urandom)}, 2'($urandom_range(0, 3)));
            run_check(v, $sformatf("rnd%0d", k));
        end

        // Abort during byte 2, then confirm a clean restart
        v = model({8'($urandom), 32'($urandom)}, 2'($urandom_range(0, 3)));
        stream = v.stream;
        leds   = v.leds;
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 3 * PollPeriod; i++) begin
                @(negedge clk);
                if (ss === 1'b0 && rise_cnt >= 18) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("abort_reached_byte2", 64'(reached), 64'd1);
        end
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("abort_ss_immediate", 64'(ss), 64'd1);
        chk("abort_sclk_low", 64'(sclk), 64'd0);
        chk("abort_no_sv", 64'(sample_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_joy_x", 64'(joy_x), 64'd512);
        chk("abort_joy_y", 64'(joy_y), 64'd512);
        chk("abort_buttons", 64'(buttons), 64'd0);
        clr = 1'b0;
        measure_start("abort");
        run_check(v, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
